// File: rtl/carry_event_fifo_pkg.sv
// Shared defaults and helpers for the carry event capture stage.
package carry_event_pkg;

    localparam int unsigned DEF_WIDTH     = 3;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_TS_WIDTH  = 8;
    localparam int unsigned DEF_CNT_WIDTH = 8;

    // FIFO operation per cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned max);
        return (cnt >= max) ? max : cnt + 1;
    endfunction

endpackage

// File: rtl/carry_event_fifo_if.sv
// Valid/ready event drain port: head record {F, timestamp} toward a monitor stage.
interface carry_event_fifo_if
    import carry_event_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned TS_WIDTH = DEF_TS_WIDTH
);
    logic                EVT_VALID;
    logic                EVT_READY;
    logic [WIDTH-1:0]    EVT_F;
    logic [TS_WIDTH-1:0] EVT_TS;

    modport master (output EVT_VALID, output EVT_F, output EVT_TS, input EVT_READY);
    modport slave  (input EVT_VALID, input EVT_F, input EVT_TS, output EVT_READY);
endinterface

// File: rtl/carry_event_fifo_fwft.sv
// Reusable first-word-fall-through synchronous FIFO with explicit occupancy counter.
module sync_fifo_fwft
    import carry_event_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    fifo_op_e      op;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A push into a full FIFO is accepted only when the head leaves the same cycle
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        op      = fifo_op_e'({do_push, do_pop});
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_PUSH: level <= level + 1'b1;
                OP_POP:  level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/carry_event_fifo.sv
// Captures each enabled counter carry as a timestamped {F, ts} record and queues it for draining.
module carry_event_fifo
    import carry_event_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned TS_WIDTH  = DEF_TS_WIDTH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     EN,
    input  logic                     COUT,
    input  logic [WIDTH-1:0]         F,
    carry_event_fifo_if.master       evt,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic [CNT_WIDTH-1:0]     CARRY_CNT,
    output logic                     DROP
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [TS_WIDTH-1:0]       ts;
    logic                      push_req;
    logic                      pop_req;
    logic                      empty;
    logic                      full;
    logic [WIDTH+TS_WIDTH-1:0] din;
    logic [WIDTH+TS_WIDTH-1:0] dout;

    assign push_req = EN & COUT;
    assign pop_req  = ~empty & evt.EVT_READY;
    assign din      = {F, ts};

    sync_fifo_fwft #(
        .W     (WIDTH + TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .CLR   (CLR),
        .push  (push_req),
        .din   (din),
        .pop   (pop_req),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .level (LEVEL)
    );

    assign evt.EVT_VALID = ~empty;
    assign evt.EVT_F     = dout[WIDTH+TS_WIDTH-1:TS_WIDTH];
    assign evt.EVT_TS    = dout[TS_WIDTH-1:0];

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ts        <= '0;
            CARRY_CNT <= '0;
            DROP      <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (push_req) begin
                CARRY_CNT <= CNT_WIDTH'(sat_inc(32'(CARRY_CNT), 32'(CNT_MAX)));
            end
            // Lost only when full and the head is not leaving this cycle
            if (push_req & full & ~pop_req) begin
                DROP <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_carry_event_fifo.sv
// Directed vector bench for carry_event_fifo: table of per-cycle vectors plus reset/wrap/saturation sequences.
module tb_carry_event_fifo;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cout;
    logic [2:0] f;
    logic [2:0] level;
    logic [7:0] carry_cnt;
    logic       drop;

    carry_event_fifo_if #(.WIDTH(3), .TS_WIDTH(8)) evt_if ();

    carry_event_fifo #(
        .WIDTH     (3),
        .DEPTH     (4),
        .TS_WIDTH  (8),
        .CNT_WIDTH (8)
    ) dut (
        .CLK       (clk),
        .CLR       (rst),
        .EN        (en),
        .COUT      (cout),
        .F         (f),
        .evt       (evt_if),
        .LEVEL     (level),
        .CARRY_CNT (carry_cnt),
        .DROP      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       cout;
        logic [2:0] f;
        logic       rdy;
        logic       v;
        logic [2:0] ef;
        logic [7:0] ets;
        logic [2:0] lvl;
        logic [7:0] cnt;
        logic       drp;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   passed;

    task automatic add(input logic e, input logic c, input logic [2:0] fi, input logic r,
                       input logic v, input logic [2:0] ef, input logic [7:0] ets,
                       input logic [2:0] lvl, input logic [7:0] cnt, input logic drp);
        vec_t t;
        t.en = e; t.cout = c; t.f = fi; t.rdy = r;
        t.v = v; t.ef = ef; t.ets = ets; t.lvl = lvl; t.cnt = cnt; t.drp = drp;
        vecs.push_back(t);
    endtask

    // Record data is only compared while a record is valid
    task automatic check_all(input string name, input logic v, input logic [2:0] ef,
                             input logic [7:0] ets, input logic [2:0] lvl,
                             input logic [7:0] cnt, input logic drp);
        logic ok;
        total++;
        ok = (evt_if.EVT_VALID === v) && (level === lvl) && (carry_cnt === cnt) && (drop === drp);
        if (v) ok = ok && (evt_if.EVT_F === ef) && (evt_if.EVT_TS === ets);
        if (ok) passed++;
        else $display("FAIL %s: got valid=%0d f=%0d ts=%0d level=%0d cnt=%0d drop=%0d, expected valid=%0d f=%0d ts=%0d level=%0d cnt=%0d drop=%0d",
                      name, evt_if.EVT_VALID, evt_if.EVT_F, evt_if.EVT_TS, level, carry_cnt, drop,
                      v, ef, ets, lvl, cnt, drp);
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic apply(input logic e, input logic c, input logic [2:0] fi, input logic r);
        en = e; cout = c; f = fi; evt_if.EVT_READY = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        en = 1'b0; cout = 1'b0; f = '0; evt_if.EVT_READY = 1'b0;

        // ts before each edge equals the vector index
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0,  0, 0, 0,   0, 0, 0);
        add(1, 1, 7, 0,  1, 7, 5,   1, 1, 0);
        add(0, 1, 0, 0,  1, 7, 5,   1, 1, 0);
        add(0, 1, 0, 1,  0, 0, 0,   0, 1, 0);
        add(1, 1, 0, 0,  1, 0, 8,   1, 2, 0);
        add(1, 1, 1, 0,  1, 0, 8,   2, 3, 0);
        add(1, 1, 2, 0,  1, 0, 8,   3, 4, 0);
        add(1, 1, 3, 0,  1, 0, 8,   4, 5, 0);
        add(1, 1, 6, 1,  1, 1, 9,   4, 6, 0);
        add(0, 0, 0, 1,  1, 2, 10,  3, 6, 0);
        add(0, 0, 0, 1,  1, 3, 11,  2, 6, 0);
        add(0, 0, 0, 1,  1, 6, 12,  1, 6, 0);
        add(0, 0, 0, 1,  0, 0, 0,   0, 6, 0);
        add(1, 1, 1, 0,  1, 1, 17,  1, 7, 0);
        add(1, 1, 2, 0,  1, 1, 17,  2, 8, 0);
        add(1, 1, 3, 0,  1, 1, 17,  3, 9, 0);
        add(1, 1, 4, 0,  1, 1, 17,  4, 10, 0);
        add(1, 1, 5, 0,  1, 1, 17,  4, 11, 1);
        add(0, 0, 0, 1,  1, 2, 18,  3, 11, 1);
        add(0, 0, 0, 1,  1, 3, 19,  2, 11, 1);
        add(0, 0, 0, 1,  1, 4, 20,  1, 11, 1);
        add(0, 0, 0, 1,  0, 0, 0,   0, 11, 1);
        add(1, 1, 7, 0,  1, 7, 26,  1, 12, 1);
        add(1, 1, 2, 1,  1, 2, 27,  1, 13, 1);
        add(1, 0, 0, 1,  0, 0, 0,   0, 13, 1);
        for (int i = 0; i < 10; i++) add(0, 1, 3, 1,  0, 0, 0,  0, 13, 1);
        add(1, 1, 5, 0,  1, 5, 39,  1, 14, 1);

        #2;
        check_all("reset_state", 0, 0, 0, 0, 0, 0);
        check_val("reset_evt_f", int'(evt_if.EVT_F), 0);
        check_val("reset_evt_ts", int'(evt_if.EVT_TS), 0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            apply(vecs[i].en, vecs[i].cout, vecs[i].f, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].ef, vecs[i].ets,
                      vecs[i].lvl, vecs[i].cnt, vecs[i].drp);
            @(negedge clk);
        end

        // Fill to three entries, then asynchronous clear before the next edge
        apply(1, 1, 1, 0);
        check_all("midrun_fill2", 1, 5, 39, 2, 15, 1);
        @(negedge clk);
        apply(1, 1, 2, 0);
        check_all("midrun_fill3", 1, 5, 39, 3, 16, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all("midrun_clr", 0, 0, 0, 0, 0, 0);
        check_val("midrun_clr_evt_f", int'(evt_if.EVT_F), 0);
        check_val("midrun_clr_evt_ts", int'(evt_if.EVT_TS), 0);
        @(negedge clk);
        check_all("clr_held", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Timestamp wrap: 300 idle edges leave ts = 300 mod 256
        for (int i = 0; i < 300; i++) begin
            apply(0, 1, 0, 0);
            @(negedge clk);
        end
        apply(1, 1, 3, 0);
        check_all("ts_wrap", 1, 3, 44, 1, 1, 0);
        @(negedge clk);

        // Continuous push+pop with READY=1 drives the tally into saturation
        for (int k = 1; k <= 260; k++) begin
            logic [7:0] kts;
            logic [2:0] kf;
            kts = 8'((44 + k) % 256);
            kf  = 3'(k % 8);
            apply(1, 1, kf, 1);
            if (k == 1)   check_all("stream_k1",   1, kf, kts, 1, 2,   0);
            if (k == 253) check_all("sat_k253",    1, kf, kts, 1, 254, 0);
            if (k == 254) check_all("sat_k254",    1, kf, kts, 1, 255, 0);
            if (k == 260) check_all("sat_k260",    1, kf, kts, 1, 255, 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
